// File: rtl/execute_stage_pkg.sv
// Shared definitions for the MIPS EX stage: ALU funct codes, forward selects, drain FSM states.
package execute_stage_pkg;

  localparam int NB_DATA_DEF      = 32;
  localparam int NB_ALU_OP_DEF    = 6;
  localparam int NB_REG_ADDR_DEF  = 5;
  localparam int NB_SHAMT_DEF     = 5;
  localparam int DRAIN_CYCLES_DEF = 3;

  localparam logic [5:0] ALU_SLL  = 6'b000000;
  localparam logic [5:0] ALU_SRL  = 6'b000010;
  localparam logic [5:0] ALU_SRA  = 6'b000011;
  localparam logic [5:0] ALU_SLLV = 6'b000100;
  localparam logic [5:0] ALU_SRLV = 6'b000110;
  localparam logic [5:0] ALU_SRAV = 6'b000111;
  localparam logic [5:0] ALU_JMP  = 6'b001001;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_SUBU = 6'b100011;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_EXM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Variable shifts take their shift amount from the low bits of rs.
  function automatic logic is_var_shift(input logic [5:0] op);
    return (op == ALU_SLLV) || (op == ALU_SRLV) || (op == ALU_SRAV);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX-side, ALU-side and EX/MEM-side signals of the EX stage; slave = EX stage, master = its environment.
interface execute_stage_if #(
  parameter int NB_DATA     = 32,
  parameter int NB_ALU_OP   = 6,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_SHAMT    = 5
);
  logic                   i_step_en;
  logic                   i_stall;
  logic                   i_flush;
  logic                   i_valid;
  logic                   i_halt;
  logic [NB_DATA-1:0]     i_rs_data;
  logic [NB_DATA-1:0]     i_rt_data;
  logic [NB_DATA-1:0]     i_imm;
  logic [NB_SHAMT-1:0]    i_shamt;
  logic [NB_DATA-1:0]     i_pc;
  logic [NB_ALU_OP-1:0]   i_alu_op;
  logic                   i_alu_src;
  logic                   i_shamt_src;
  logic                   i_link;
  logic [1:0]             i_fwd_a;
  logic [1:0]             i_fwd_b;
  logic [NB_DATA-1:0]     i_wb_data;
  logic [NB_REG_ADDR-1:0] i_rd_addr;
  logic                   i_reg_write;
  logic                   i_mem_read;
  logic                   i_mem_write;
  logic [NB_DATA-1:0]     o_alu_a;
  logic [NB_DATA-1:0]     o_alu_b;
  logic [NB_ALU_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0]     i_alu_result;
  logic [NB_DATA-1:0]     o_exm_result;
  logic [NB_DATA-1:0]     o_exm_store_data;
  logic [NB_REG_ADDR-1:0] o_exm_rd_addr;
  logic                   o_exm_reg_write;
  logic                   o_exm_mem_read;
  logic                   o_exm_mem_write;
  logic                   o_exm_valid;
  logic                   o_halted;

  modport slave (
    input  i_step_en, i_stall, i_flush, i_valid, i_halt,
    input  i_rs_data, i_rt_data, i_imm, i_shamt, i_pc,
    input  i_alu_op, i_alu_src, i_shamt_src, i_link,
    input  i_fwd_a, i_fwd_b, i_wb_data,
    input  i_rd_addr, i_reg_write, i_mem_read, i_mem_write,
    input  i_alu_result,
    output o_alu_a, o_alu_b, o_alu_op,
    output o_exm_result, o_exm_store_data, o_exm_rd_addr,
    output o_exm_reg_write, o_exm_mem_read, o_exm_mem_write,
    output o_exm_valid, o_halted
  );

  modport master (
    output i_step_en, i_stall, i_flush, i_valid, i_halt,
    output i_rs_data, i_rt_data, i_imm, i_shamt, i_pc,
    output i_alu_op, i_alu_src, i_shamt_src, i_link,
    output i_fwd_a, i_fwd_b, i_wb_data,
    output i_rd_addr, i_reg_write, i_mem_read, i_mem_write,
    output i_alu_result,
    input  o_alu_a, o_alu_b, o_alu_op,
    input  o_exm_result, o_exm_store_data, o_exm_rd_addr,
    input  o_exm_reg_write, o_exm_mem_read, o_exm_mem_write,
    input  o_exm_valid, o_halted
  );
endinterface

// File: rtl/execute_stage_operand_mux.sv
// Combinational ALU operand and store-data selection for the EX stage.
// Forwarding muxes exist only when EXECUTE_STAGE_FORWARDING_EN is defined.
module ex_operand_mux
  import execute_stage_pkg::*;
#(
  parameter int NB_DATA   = 32,
  parameter int NB_ALU_OP = 6,
  parameter int NB_SHAMT  = 5
) (
  input  logic [NB_DATA-1:0]   rs_data_i,
  input  logic [NB_DATA-1:0]   rt_data_i,
  input  logic [NB_DATA-1:0]   imm_i,
  input  logic [NB_SHAMT-1:0]  shamt_i,
  input  logic [NB_DATA-1:0]   pc_i,
  input  logic [NB_ALU_OP-1:0] alu_op_i,
  input  logic                 alu_src_i,
  input  logic                 shamt_src_i,
  input  logic                 link_i,
  input  logic [1:0]           fwd_a_i,
  input  logic [1:0]           fwd_b_i,
  input  logic [NB_DATA-1:0]   wb_data_i,
  input  logic [NB_DATA-1:0]   exm_result_i,
  output logic [NB_DATA-1:0]   alu_a_o,
  output logic [NB_DATA-1:0]   alu_b_o,
  output logic [NB_DATA-1:0]   store_data_o
);

  logic [NB_DATA-1:0] fwd_rs;
  logic [NB_DATA-1:0] fwd_rt;

`ifdef EXECUTE_STAGE_FORWARDING_EN
  // Select 11 is not a legal encoding and falls back to the ID/EX value.
  always_comb begin
    fwd_rs = rs_data_i;
    if (fwd_a_i == FWD_EXM)     fwd_rs = exm_result_i;
    else if (fwd_a_i == FWD_WB) fwd_rs = wb_data_i;
  end

  always_comb begin
    fwd_rt = rt_data_i;
    if (fwd_b_i == FWD_EXM)     fwd_rt = exm_result_i;
    else if (fwd_b_i == FWD_WB) fwd_rt = wb_data_i;
  end
`else
  logic unused_fwd;
  assign fwd_rs     = rs_data_i;
  assign fwd_rt     = rt_data_i;
  assign unused_fwd = ^{fwd_a_i, fwd_b_i, wb_data_i, exm_result_i};
`endif

  always_comb begin
    alu_a_o = fwd_rs;
    if (link_i)
      alu_a_o = pc_i;
    else if (shamt_src_i)
      alu_a_o = {{(NB_DATA-NB_SHAMT){1'b0}}, shamt_i};
    else if (is_var_shift(alu_op_i))
      alu_a_o = {{(NB_DATA-NB_SHAMT){1'b0}}, fwd_rs[NB_SHAMT-1:0]};
  end

  assign alu_b_o      = alu_src_i ? imm_i : fwd_rt;
  assign store_data_o = fwd_rt;

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: operand selection, EX/MEM latch with step/flush/stall, HALT drain FSM.
// Optional forwarding via EXECUTE_STAGE_FORWARDING_EN.
//   state     | meaning
//   ST_RUN    | normal operation, captures real instructions
//   ST_DRAIN  | HALT captured, counting stepped cycles, latching bubbles
//   ST_HALTED | pipeline empty, o_halted high until reset
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int NB_DATA      = NB_DATA_DEF,
  parameter int NB_ALU_OP    = NB_ALU_OP_DEF,
  parameter int NB_REG_ADDR  = NB_REG_ADDR_DEF,
  parameter int NB_SHAMT     = NB_SHAMT_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input logic            i_clk,
  input logic            i_rst_n,
  execute_stage_if.slave ex_if
);

  localparam int NB_CNT = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_e                 state_q;
  logic [NB_CNT-1:0]      cnt_q;
  logic                   halted_q;
  logic [NB_DATA-1:0]     result_q;
  logic [NB_DATA-1:0]     store_q;
  logic [NB_REG_ADDR-1:0] rd_q;
  logic                   reg_write_q;
  logic                   mem_read_q;
  logic                   mem_write_q;
  logic                   valid_q;

  logic [NB_DATA-1:0]     store_data_d;
  logic                   capture_d;
  logic                   cap_valid_d;

  ex_operand_mux #(
    .NB_DATA   (NB_DATA),
    .NB_ALU_OP (NB_ALU_OP),
    .NB_SHAMT  (NB_SHAMT)
  ) u_operand_mux (
    .rs_data_i    (ex_if.i_rs_data),
    .rt_data_i    (ex_if.i_rt_data),
    .imm_i        (ex_if.i_imm),
    .shamt_i      (ex_if.i_shamt),
    .pc_i         (ex_if.i_pc),
    .alu_op_i     (ex_if.i_alu_op),
    .alu_src_i    (ex_if.i_alu_src),
    .shamt_src_i  (ex_if.i_shamt_src),
    .link_i       (ex_if.i_link),
    .fwd_a_i      (ex_if.i_fwd_a),
    .fwd_b_i      (ex_if.i_fwd_b),
    .wb_data_i    (ex_if.i_wb_data),
    .exm_result_i (result_q),
    .alu_a_o      (ex_if.o_alu_a),
    .alu_b_o      (ex_if.o_alu_b),
    .store_data_o (store_data_d)
  );

  assign capture_d   = ex_if.i_step_en && !ex_if.i_flush && !ex_if.i_stall;
  // HALT itself and anything after it are latched as bubbles.
  assign cap_valid_d = ex_if.i_valid && !ex_if.i_halt && (state_q == ST_RUN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
      result_q    <= '0;
      store_q     <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      valid_q     <= 1'b0;
    end else if (ex_if.i_step_en) begin
      if (ex_if.i_flush) begin
        valid_q     <= 1'b0;
        reg_write_q <= 1'b0;
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
      end else if (!ex_if.i_stall) begin
        result_q    <= ex_if.i_alu_result;
        store_q     <= store_data_d;
        rd_q        <= ex_if.i_rd_addr;
        valid_q     <= cap_valid_d;
        reg_write_q <= ex_if.i_reg_write && cap_valid_d;
        mem_read_q  <= ex_if.i_mem_read && cap_valid_d;
        mem_write_q <= ex_if.i_mem_write && cap_valid_d;
      end

      unique case (state_q)
        ST_RUN: begin
          if (capture_d && ex_if.i_valid && ex_if.i_halt) begin
            state_q <= ST_DRAIN;
            cnt_q   <= NB_CNT'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          if (cnt_q <= NB_CNT'(1)) begin
            state_q  <= ST_HALTED;
            cnt_q    <= '0;
            halted_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - NB_CNT'(1);
          end
        end
        ST_HALTED: halted_q <= 1'b1;
        default:   state_q  <= ST_RUN;
      endcase
    end
  end

  assign ex_if.o_alu_op         = ex_if.i_alu_op;
  assign ex_if.o_exm_result     = result_q;
  assign ex_if.o_exm_store_data = store_q;
  assign ex_if.o_exm_rd_addr    = rd_q;
  assign ex_if.o_exm_reg_write  = reg_write_q;
  assign ex_if.o_exm_mem_read   = mem_read_q;
  assign ex_if.o_exm_mem_write  = mem_write_q;
  assign ex_if.o_exm_valid      = valid_q;
  assign ex_if.o_halted         = halted_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors, reference ALU, queue-based EX/MEM checking.
module tb_execute_stage;
  import execute_stage_pkg::*;

`ifdef EXECUTE_STAGE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_res;
  logic        cap_seen = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];
  logic [3:0]  step_pat = 4'b1101;

  execute_stage_if ex_if ();

  execute_stage dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .ex_if   (ex_if)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_res = '0;
    case (ex_if.o_alu_op)
      ALU_ADDU:          alu_res = ex_if.o_alu_a + ex_if.o_alu_b;
      ALU_SUBU:          alu_res = ex_if.o_alu_a - ex_if.o_alu_b;
      ALU_AND:           alu_res = ex_if.o_alu_a & ex_if.o_alu_b;
      ALU_OR:            alu_res = ex_if.o_alu_a | ex_if.o_alu_b;
      ALU_XOR:           alu_res = ex_if.o_alu_a ^ ex_if.o_alu_b;
      ALU_JMP:           alu_res = ex_if.o_alu_a + 32'd4;
      ALU_SLL, ALU_SLLV: alu_res = ex_if.o_alu_b << ex_if.o_alu_a[4:0];
      ALU_SRL, ALU_SRLV: alu_res = ex_if.o_alu_b >> ex_if.o_alu_a[4:0];
      ALU_SRA, ALU_SRAV: alu_res = $signed(ex_if.o_alu_b) >>> ex_if.o_alu_a[4:0];
      ALU_SLT:           alu_res = {31'd0, $signed(ex_if.o_alu_a) < $signed(ex_if.o_alu_b)};
      default:           alu_res = '0;
    endcase
  end
  assign ex_if.i_alu_result = alu_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk)
    cap_seen = ex_if.i_step_en && !ex_if.i_flush && !ex_if.i_stall && rst_n;

  always @(negedge clk) begin
    exp_t e;
    if (cap_seen && ex_if.o_exm_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected actual=valid result 0x%0h required=no entry t=%0t",
                 ex_if.o_exm_result, $time);
      end else begin
        e = sb_q.pop_front();
        chk("sb_result", ex_if.o_exm_result, e.result);
        chk("sb_store", ex_if.o_exm_store_data, e.store);
        chk("sb_rd", 32'(ex_if.o_exm_rd_addr), 32'(e.rd));
        chk("sb_ctrl", {29'd0, ex_if.o_exm_reg_write, ex_if.o_exm_mem_read, ex_if.o_exm_mem_write},
            {29'd0, e.rw, e.mr, e.mw});
      end
    end
  end

  task automatic clr();
    ex_if.i_step_en   = 1'b1;
    ex_if.i_stall     = 1'b0;
    ex_if.i_flush     = 1'b0;
    ex_if.i_valid     = 1'b0;
    ex_if.i_halt      = 1'b0;
    ex_if.i_rs_data   = '0;
    ex_if.i_rt_data   = '0;
    ex_if.i_imm       = '0;
    ex_if.i_shamt     = '0;
    ex_if.i_pc        = '0;
    ex_if.i_alu_op    = ALU_ADDU;
    ex_if.i_alu_src   = 1'b0;
    ex_if.i_shamt_src = 1'b0;
    ex_if.i_link      = 1'b0;
    ex_if.i_fwd_a     = 2'b00;
    ex_if.i_fwd_b     = 2'b00;
    ex_if.i_wb_data   = '0;
    ex_if.i_rd_addr   = '0;
    ex_if.i_reg_write = 1'b0;
    ex_if.i_mem_read  = 1'b0;
    ex_if.i_mem_write = 1'b0;
  endtask

  task automatic op3(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [4:0] rd);
    clr();
    ex_if.i_valid     = 1'b1;
    ex_if.i_alu_op    = op;
    ex_if.i_rs_data   = rs;
    ex_if.i_rt_data   = rt;
    ex_if.i_rd_addr   = rd;
    ex_if.i_reg_write = 1'b1;
  endtask

  task automatic push(input logic [31:0] res, input logic [31:0] st, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic mw);
    exp_t e;
    e.result = res; e.store = st; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw;
    sb_q.push_back(e);
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, 32'(ex_if.o_exm_valid), 32'd0);
    chk({tag, "_result"}, ex_if.o_exm_result, 32'd0);
    chk({tag, "_store"}, ex_if.o_exm_store_data, 32'd0);
    chk({tag, "_rd"}, 32'(ex_if.o_exm_rd_addr), 32'd0);
    chk({tag, "_ctrl"}, {29'd0, ex_if.o_exm_reg_write, ex_if.o_exm_mem_read, ex_if.o_exm_mem_write}, 32'd0);
    chk({tag, "_halted"}, 32'(ex_if.o_halted), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    adv(); adv();
    chk_cleared("reset");
    rst_n = 1'b1;

    op3(ALU_ADDU, 32'd5, 32'd7, 5'd3);
    #1 chk("addu_a", ex_if.o_alu_a, 32'd5);
    chk("addu_b", ex_if.o_alu_b, 32'd7);
    chk("addu_op", 32'(ex_if.o_alu_op), 32'(ALU_ADDU));
    push(32'd12, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0);
    adv();

    op3(ALU_SLLV, 32'h24, 32'd1, 5'd4);
    #1 chk("sllv_a", ex_if.o_alu_a, 32'd4);
    push(32'd16, 32'd1, 5'd4, 1'b1, 1'b0, 1'b0);
    adv();

    op3(ALU_SLL, 32'd0, 32'd2, 5'd5);
    ex_if.i_shamt_src = 1'b1;
    ex_if.i_shamt     = 5'd3;
    #1 chk("sll_a", ex_if.o_alu_a, 32'd3);
    chk("sll_b", ex_if.o_alu_b, 32'd2);
    push(32'd16, 32'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    adv();

    op3(ALU_ADDU, 32'd1, 32'd2, 5'd1);
    push(32'd3, 32'd2, 5'd1, 1'b1, 1'b0, 1'b0);
    adv();

    op3(ALU_ADDU, 32'h55, 32'h10, 5'd2);
    ex_if.i_fwd_a   = 2'b01;
    ex_if.i_fwd_b   = 2'b10;
    ex_if.i_wb_data = 32'd9;
    #1 chk("fwd_a_exm", ex_if.o_alu_a, FWD ? 32'd3 : 32'h55);
    chk("fwd_b_wb", ex_if.o_alu_b, FWD ? 32'd9 : 32'h10);
    push(FWD ? 32'd12 : 32'h65, FWD ? 32'd9 : 32'h10, 5'd2, 1'b1, 1'b0, 1'b0);
    adv();

    op3(ALU_ADDU, 32'h20, 32'h30, 5'd2);
    ex_if.i_fwd_a   = 2'b11;
    ex_if.i_fwd_b   = 2'b11;
    ex_if.i_wb_data = 32'd9;
    #1 chk("fwd11_a", ex_if.o_alu_a, 32'h20);
    chk("fwd11_b", ex_if.o_alu_b, 32'h30);
    push(32'h50, 32'h30, 5'd2, 1'b1, 1'b0, 1'b0);
    adv();

    op3(ALU_ADDU, 32'h100, 32'hAB, 5'd0);
    ex_if.i_reg_write = 1'b0;
    ex_if.i_mem_write = 1'b1;
    ex_if.i_alu_src   = 1'b1;
    ex_if.i_imm       = 32'd8;
    #1 chk("sw_b_imm", ex_if.o_alu_b, 32'd8);
    push(32'h108, 32'hAB, 5'd0, 1'b0, 1'b0, 1'b1);
    adv();

    op3(ALU_JMP, 32'h999, 32'd0, 5'd31);
    ex_if.i_link = 1'b1;
    ex_if.i_pc   = 32'h40;
    #1 chk("jal_a", ex_if.o_alu_a, 32'h40);
    push(32'h44, 32'd0, 5'd31, 1'b1, 1'b0, 1'b0);
    adv();

    op3(ALU_ADDU, 32'd1, 32'd1, 5'd7);
    ex_if.i_mem_read = 1'b1;
    ex_if.i_valid    = 1'b0;
    adv();
    chk("bubble_valid", 32'(ex_if.o_exm_valid), 32'd0);
    chk("bubble_ctrl", {30'd0, ex_if.o_exm_reg_write, ex_if.o_exm_mem_read}, 32'd0);

    op3(ALU_ADDU, 32'd2, 32'd3, 5'd6);
    push(32'd5, 32'd3, 5'd6, 1'b1, 1'b0, 1'b0);
    adv();

    op3(ALU_ADDU, 32'd100, 32'd100, 5'd7);
    ex_if.i_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      adv();
      chk("stall_result", ex_if.o_exm_result, 32'd5);
      chk("stall_valid", 32'(ex_if.o_exm_valid), 32'd1);
      chk("stall_rd", 32'(ex_if.o_exm_rd_addr), 32'd6);
    end
    ex_if.i_flush = 1'b1;
    adv();
    chk("flush_valid", 32'(ex_if.o_exm_valid), 32'd0);
    chk("flush_rw", 32'(ex_if.o_exm_reg_write), 32'd0);
    chk("flush_result_hold", ex_if.o_exm_result, 32'd5);

    op3(ALU_ADDU, 32'd50, 32'd50, 5'd8);
    ex_if.i_step_en = 1'b0;
    adv();
    chk("freeze_valid", 32'(ex_if.o_exm_valid), 32'd0);
    chk("freeze_result", ex_if.o_exm_result, 32'd5);

    op3(ALU_ADDU, 32'd1, 32'd1, 5'd9);
    ex_if.i_halt = 1'b1;
    adv();
    chk("halt_valid", 32'(ex_if.o_exm_valid), 32'd0);
    chk("halt_rw", 32'(ex_if.o_exm_reg_write), 32'd0);
    chk("halt_halted", 32'(ex_if.o_halted), 32'd0);
    for (int i = 0; i < 4; i++) begin
      op3(ALU_ADDU, 32'd10, 32'd10, 5'd10);
      ex_if.i_step_en = step_pat[i];
      adv();
      chk("drain_halted", 32'(ex_if.o_halted), (i == 3) ? 32'd1 : 32'd0);
      chk("drain_valid", 32'(ex_if.o_exm_valid), 32'd0);
    end
    op3(ALU_ADDU, 32'd10, 32'd10, 5'd10);
    adv();
    chk("halted_valid", 32'(ex_if.o_exm_valid), 32'd0);
    chk("halted_hold", 32'(ex_if.o_halted), 32'd1);

    clr();
    #2 rst_n = 1'b0;
    #1 chk("rst_halted", 32'(ex_if.o_halted), 32'd0);
    adv();
    rst_n = 1'b1;
    op3(ALU_ADDU, 32'd1, 32'd1, 5'd9);
    ex_if.i_halt = 1'b1;
    adv();
    op3(ALU_ADDU, 32'd10, 32'd10, 5'd10);
    adv();
    #2 rst_n = 1'b0;
    #1 chk_cleared("rst_drain");
    adv();
    rst_n = 1'b1;
    op3(ALU_ADDU, 32'd4, 32'd4, 5'd8);
    push(32'd8, 32'd4, 5'd8, 1'b1, 1'b0, 1'b0);
    adv();
    clr();
    repeat (4) adv();
    chk("post_rst_halted", 32'(ex_if.o_halted), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline. Sits between the ID/EX outputs and the ALU.
- Selects and forwards the ALU operands, drives the ALU combinationally and takes its result back.
- Registers the result and control into the EX/MEM latch, with stall, flush and debug-step control.
- Contains a HALT drain FSM that reports to the debug unit when the pipeline has emptied after a HALT.

Parameters:
NB_DATA, 32, datapath width
NB_ALU_OP, 6, ALU op-code width (funct encoding)
NB_REG_ADDR, 5, register-file address width
NB_SHAMT, 5, shift-amount width
DRAIN_CYCLES, 3, stepped cycles after HALT capture before o_halted asserts

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
i_step_en  in  1  debug-unit advance enable; 0 freezes all state
i_stall  in  1  hold the EX/MEM latch (MEM busy)
i_flush  in  1  load a bubble into the EX/MEM latch
i_valid  in  1  the ID/EX instruction is real (not a bubble)
i_halt  in  1  the ID/EX instruction is HALT
i_rs_data  in  NB_DATA  rs value from ID/EX
i_rt_data  in  NB_DATA  rt value from ID/EX
i_imm  in  NB_DATA  sign-extended immediate
i_shamt  in  NB_SHAMT  instruction shamt field
i_pc  in  NB_DATA  PC+4 of the instruction
i_alu_op  in  NB_ALU_OP  ALU operation
i_alu_src  in  1  B = imm (1) or rt (0)
i_shamt_src  in  1  A = zero-extended shamt
i_link  in  1  A = i_pc (jal/jalr)
i_fwd_a  in  2  A forward select: 00 none, 01 EX/MEM, 10 MEM/WB
i_fwd_b  in  2  B forward select, same encoding as i_fwd_a
i_wb_data  in  NB_DATA  MEM/WB writeback value
i_rd_addr  in  NB_REG_ADDR  destination register
i_reg_write  in  1  register-write control
i_mem_read  in  1  load control
i_mem_write  in  1  store control
o_alu_a  out  NB_DATA  ALU operand A (combinational)
o_alu_b  out  NB_DATA  ALU operand B (combinational)
o_alu_op  out  NB_ALU_OP  ALU op (pass-through)
i_alu_result  in  NB_DATA  ALU result
o_exm_result  out  NB_DATA  registered ALU result
o_exm_store_data  out  NB_DATA  registered forwarded rt
o_exm_rd_addr  out  NB_REG_ADDR  registered destination register
o_exm_reg_write  out  1  registered register-write control
o_exm_mem_read  out  1  registered load control
o_exm_mem_write  out  1  registered store control
o_exm_valid  out  1  EX/MEM latch holds a real instruction
o_halted  out  1  pipeline drained after HALT

Behaviour:
- Reset: every o_exm_* output is 0, o_halted = 0, FSM in RUN, drain counter 0.
- Operand A, in priority order:
  - i_link -> i_pc (the ALU op 001001 adds 4, giving PC+8).
  - i_shamt_src -> {zeros, i_shamt}.
  - Otherwise the forwarded rs.
  - For ops 000100, 000110 and 000111, A is forced to {zeros, fwd_rs[4:0]}.
- Operand B: i_alu_src ? i_imm : forwarded rt.
- Forwarding: 01 selects o_exm_result, 10 selects i_wb_data, 11 is treated as 00.
- Store data is always the forwarded rt, independent of i_alu_src.
- Latch update, per rising edge, in this priority:
  - !i_step_en: hold all state.
  - i_flush: bubble; valid, reg_write, mem_read and mem_write go to 0; data fields hold.
  - i_stall: hold.
  - Otherwise capture. o_exm_valid = i_valid and FSM == RUN. Control bits are ANDed with the captured valid.
- Flush and stall asserted together: flush wins.
- Latency: one cycle from ID/EX inputs to the o_exm_* outputs.
- FSM:
  - RUN -> DRAIN on a capture with i_valid and i_halt. The HALT itself is latched as a bubble (no writes). The counter loads DRAIN_CYCLES.
  - DRAIN: decrement on each i_step_en cycle; all captures are bubbles. At 0 -> HALTED.
  - HALTED: o_halted = 1 and latch keeps bubbles until reset.
- A reset mid-DRAIN returns to RUN with all outputs cleared.

Optional Feature:
- Macro EXECUTE_STAGE_FORWARDING_EN.
- Defined: forwarding muxes are active as described.
- Undefined: i_fwd_a and i_fwd_b are ignored, operands come straight from i_rs_data / i_rt_data, and no path from o_exm_result to the operand muxes exists.

Decomposition:
- Shared package holds:
  - ALU op localparams (addu 100001, sllv 000100, srlv 000110, srav 000111, jmp 001001, ...).
  - Forward-select encodings FWD_NONE, FWD_EXM, FWD_WB.
  - FSM state encodings ST_RUN, ST_DRAIN, ST_HALTED.
- One sub-module: ex_operand_mux (purely combinational A/B/store-data selection). Latch and FSM stay in execute_stage.

Test Plan:
- Step=1, addu, rs=5, rt=7, no fwd, ALU tied to a reference model -> next cycle o_exm_result=12, o_exm_valid=1.
- sllv, rs=0x00000024, rt=1 -> o_alu_a=4, result 16. sll with shamt=3, rt=2 -> o_alu_a=3, result 16.
- Back-to-back: addu r1=1+2, then addu with i_fwd_a=01 -> o_alu_a=3. With i_fwd_b=10 and i_wb_data=9 -> o_alu_b=9.
- stall=1 for 2 cycles, then flush=1 and stall=1 together -> latch holds, then o_exm_valid=0 with reg_write=0.
- HALT with valid, DRAIN_CYCLES=3, step toggled 1,0,1,1 -> o_halted rises only after the 3rd stepped cycle after capture. Every latched entry is a bubble.
- Assert i_rst_n low mid-DRAIN -> all outputs 0 immediately (asynchronous). After release the next instruction is captured normally.
